// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM encodings, ACK/NACK levels and the default
// PCF8574 backpack address used by both the target model and i2c_master users.
package i2c_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAddr    = 3'd1,
    StAddrAck = 3'd2,
    StWrByte  = 3'd3,
    StWrAck   = 3'd4,
    StRdByte  = 3'd5,
    StRdAck   = 3'd6,
    StIgnore  = 3'd7
  } i2c_state_e;

  localparam logic       ACK          = 1'b0;
  localparam logic       NACK         = 1'b1;
  localparam logic [6:0] PCF8574_ADDR = 7'h27;

  localparam logic [3:0] BitsPerByte  = 4'd8;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchroniser for one asynchronous bus line, with registered level and
// single-cycle rise/fall strobes derived from the synchronised value.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_p_i,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Idle bus level is high, so reset to 1 to avoid spurious edges after reset.
  always_ff @(posedge clk_i or posedge reset_p_i) begin
    if (reset_p_i) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/i2c_pcf8574_target.sv
// I2C target emulating a PCF8574 expander: ACKs its address, presents written
// bytes on o_data/o_valid and returns i_port on reads.
module i2c_pcf8574_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = PCF8574_ADDR,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_low,
  input  logic [7:0] i_port,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_busy
);

  logic scl_level, scl_rise, scl_fall;
  logic sda_level, sda_rise, sda_fall;
  logic start_cond, stop_cond;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_scl_sync (
    .clk_i    (clk),
    .reset_p_i(reset_p),
    .line_i   (i_scl),
    .level_o  (scl_level),
    .rise_o   (scl_rise),
    .fall_o   (scl_fall)
  );

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sda_sync (
    .clk_i    (clk),
    .reset_p_i(reset_p),
    .line_i   (i_sda),
    .level_o  (sda_level),
    .rise_o   (sda_rise),
    .fall_o   (sda_fall)
  );

  assign start_cond = sda_fall & scl_level;
  assign stop_cond  = sda_rise & scl_level;

  i2c_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       sda_low_q, sda_low_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      sda_low_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      sda_low_q <= sda_low_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    sda_low_d = sda_low_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;

    // Bus conditions override any bit activity, including a coincident SCL fall.
    if (start_cond) begin
      state_d   = StAddr;
      bit_cnt_d = '0;
      sda_low_d = 1'b0;
    end else if (stop_cond) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StIgnore: begin
        end

        StAddr: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_level};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == BitsPerByte - 4'd1) begin
              bit_cnt_d = '0;
              if (shift_q[6:0] == DEV_ADDR) begin
                state_d = StAddrAck;
                busy_d  = 1'b1;
              end else begin
                state_d = StIgnore;
              end
            end
          end
        end

        // First fall drives the ACK; the second ends it (shift_q[0] holds R/W).
        StAddrAck: begin
          if (scl_fall) begin
            if (!sda_low_q) begin
              sda_low_d = 1'b1;
            end else if (shift_q[0]) begin
              sda_low_d = ~i_port[7];
              shift_d   = {i_port[6:0], 1'b0};
              bit_cnt_d = 4'd1;
              state_d   = StRdByte;
            end else begin
              sda_low_d = 1'b0;
              bit_cnt_d = '0;
              state_d   = StWrByte;
            end
          end
        end

        StWrByte: begin
          if (scl_rise && (bit_cnt_q < BitsPerByte)) begin
            shift_d   = {shift_q[6:0], sda_level};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && (bit_cnt_q == BitsPerByte)) begin
            data_d    = shift_q;
            valid_d   = 1'b1;
            sda_low_d = 1'b1;
            bit_cnt_d = '0;
            state_d   = StWrAck;
          end
        end

        StWrAck: begin
          if (scl_fall) begin
            sda_low_d = 1'b0;
            state_d   = StWrByte;
          end
        end

        StRdByte: begin
          if (scl_fall) begin
            if (bit_cnt_q == BitsPerByte) begin
              sda_low_d = 1'b0;
              bit_cnt_d = '0;
              state_d   = StRdAck;
            end else begin
              sda_low_d = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        StRdAck: begin
          if (scl_rise) begin
            bit_cnt_d = '0;
            if (sda_level == ACK) begin
              shift_d = i_port;
              state_d = StRdByte;
            end else begin
              busy_d  = 1'b0;
              state_d = StIgnore;
            end
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign o_sda_low = sda_low_q;
  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_i2c_pcf8574_target.sv
// Bench for i2c_pcf8574_target: bit-level I2C master BFM, pull-up bus model and
// an o_data scoreboard fed by the master and drained by an o_valid monitor.
module tb_i2c_pcf8574_target;

  // SCL quarter period of 10 clk (SCL = clk/40) keeps the run short.
  localparam int Q = 100;

  logic       clk = 1'b0;
  logic       reset_p;
  logic       scl;
  logic       msda;
  logic       sda_bus;
  logic       o_sda_low;
  logic [7:0] i_port;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_busy;

  assign sda_bus = ~o_sda_low & msda;

  always #5 clk = ~clk;

  i2c_pcf8574_target #(
    .DEV_ADDR   (7'h27),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .reset_p  (reset_p),
    .i_scl    (scl),
    .i_sda    (sda_bus),
    .o_sda_low(o_sda_low),
    .i_port   (i_port),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_busy   (o_busy)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         sda_low_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every o_valid pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (o_sda_low) sda_low_cnt <= sda_low_cnt + 1;
    if (o_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_valid: got o_data 0x%0h, expected no o_valid", o_data);
      end else begin
        check("sb_o_data", {24'h0, o_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: got no end of test, expected finish within 800 us");
    $fatal(1, "bench timed out");
  end

  task automatic bit_xfer(input logic b, output logic s);
    #Q msda = b;
    #Q scl = 1'b1;
    #Q s = sda_bus;
    #Q scl = 1'b0;
  endtask

  task automatic bus_start();
    #Q msda = 1'b1;
    #Q scl = 1'b1;
    #Q msda = 1'b0;
    #Q scl = 1'b0;
  endtask

  task automatic bus_stop();
    #Q msda = 1'b0;
    #Q scl = 1'b1;
    #Q msda = 1'b1;
    #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string name);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
    bit_xfer(1'b1, s);
    check({name, "_ack"}, {31'h0, s}, {31'h0, exp_ack});
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic mack, input string name);
    logic       s;
    logic [7:0] r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      r[i] = s;
    end
    check(name, {24'h0, r}, {24'h0, exp});
    bit_xfer(mack, s);
    check({name, "_ack_bus"}, {31'h0, s}, {31'h0, mack});
  endtask

  initial begin
    logic       s;
    int         snap;
    int         kind;
    int         nb;
    logic [7:0] addr;
    logic [7:0] d;
    logic       match;

    reset_p = 1'b1;
    scl     = 1'b1;
    msda    = 1'b1;
    i_port  = 8'h00;
    #53;
    check("rst_sda_low", {31'h0, o_sda_low}, 32'h0);
    check("rst_o_data", {24'h0, o_data}, 32'h0);
    check("rst_o_valid", {31'h0, o_valid}, 32'h0);
    check("rst_o_busy", {31'h0, o_busy}, 32'h0);
    reset_p = 1'b0;
    #(4 * Q);

    // 1: simple write
    bus_start();
    write_byte(8'h4E, 1'b0, "t1_addr");
    check("t1_busy_on", {31'h0, o_busy}, 32'h1);
    exp_q.push_back(8'h0C);
    write_byte(8'h0C, 1'b0, "t1_data");
    bus_stop();
    #(2 * Q);
    check("t1_busy_off", {31'h0, o_busy}, 32'h0);
    check("t1_o_data", {24'h0, o_data}, 32'h0C);

    // 2: foreign address is ignored
    snap = sda_low_cnt;
    bus_start();
    write_byte(8'h50, 1'b1, "t2_addr");
    check("t2_busy", {31'h0, o_busy}, 32'h0);
    write_byte(8'hFF, 1'b1, "t2_data");
    bus_stop();
    check("t2_no_drive", sda_low_cnt - snap, 32'h0);

    // 3: single read, master NACK
    i_port = 8'hA5;
    bus_start();
    write_byte(8'h4F, 1'b0, "t3_addr");
    read_byte(8'hA5, 1'b1, "t3_rd");
    check("t3_busy_nack", {31'h0, o_busy}, 32'h0);
    bus_stop();

    // 4: two-byte read
    i_port = 8'h3C;
    bus_start();
    write_byte(8'h4F, 1'b0, "t4_addr");
    read_byte(8'h3C, 1'b0, "t4_rd0");
    read_byte(8'h3C, 1'b1, "t4_rd1");
    bus_stop();
    check("t4_busy", {31'h0, o_busy}, 32'h0);

    // 5: partial byte then repeated START
    bus_start();
    write_byte(8'h4E, 1'b0, "t5_addr0");
    for (int i = 0; i < 5; i++) bit_xfer(1'(i % 2), s);
    bus_start();
    check("t5_partial_kept", {24'h0, o_data}, 32'h0C);
    write_byte(8'h4E, 1'b0, "t5_addr1");
    exp_q.push_back(8'h81);
    write_byte(8'h81, 1'b0, "t5_data");
    bus_stop();
    check("t5_o_data", {24'h0, o_data}, 32'h81);

    // 6: reset while the address ACK is driven
    bus_start();
    for (int i = 7; i >= 0; i--) bit_xfer(1'(8'h4E >> i), s);
    for (int i = 0; i < 30 && !o_sda_low; i++) @(negedge clk);
    check("t6_ack_drive", {31'h0, o_sda_low}, 32'h1);
    reset_p = 1'b1;
    #1;
    check("t6_rst_sda_low", {31'h0, o_sda_low}, 32'h0);
    check("t6_rst_o_data", {24'h0, o_data}, 32'h0);
    check("t6_rst_busy", {31'h0, o_busy}, 32'h0);
    #30 reset_p = 1'b0;
    snap = sda_low_cnt;
    bit_xfer(1'b1, s);
    check("t6_ack_after_rst", {31'h0, s}, 32'h1);
    write_byte(8'h55, 1'b1, "t6_data");
    bus_stop();
    check("t6_no_drive", sda_low_cnt - snap, 32'h0);

    // Random transactions against the address/direction model
    for (int t = 0; t < 12; t++) begin
      kind   = int'($urandom_range(0, 2));
      addr   = (kind == 0) ? 8'h4E : (kind == 1) ? 8'h4F : 8'($urandom);
      nb     = int'($urandom_range(1, 3));
      i_port = 8'($urandom);
      match  = (addr[7:1] == 7'h27);
      bus_start();
      write_byte(addr, !match, "rnd_addr");
      for (int b = 0; b < nb; b++) begin
        if (match && addr[0]) begin
          read_byte(i_port, (b == nb - 1), "rnd_rd");
        end else begin
          d = 8'($urandom);
          if (match) exp_q.push_back(d);
          write_byte(d, !match, "rnd_wr");
        end
      end
      bus_stop();
      #(2 * Q);
      check("rnd_busy", {31'h0, o_busy}, 32'h0);
    end

    #(4 * Q);
    check("sb_drain", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
